dct_arb: RTL and testbench

- Shares one 1-D DCT row engine between N pixel-row requesters, e.g. the Y, Cb and Cr streams.
- Arbitration is block-granular and round-robin: a granted requester owns the engine from its sob row through its eob row (8 rows).
- A tag pipeline, matched to the engine latency, steers each engine result row back to its originating channel.
- Sits between the colour/blocking front end and the DCT engine.

---
 rtl/dct_arb.sv | 188 ++++++++++++++++++
 tb/tb_dct_arb.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dct_arb.sv
// dct_arb: shares one 1-D DCT row engine between N pixel-row requesters.
// Ownership is block-granular (sob..eob, at most ROWS rows) with round-robin
// selection between blocks. A {valid, channel} tag pipeline matched to the
// engine latency steers each result row back to the channel it came from.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_*             per-requester row stream (valid/ready handshake)
//   dct_*             registered row stream into the engine (no backpressure)
//   dct_res_*         engine result row stream
//   out_valid         one-hot result valid; out_data/out_sob/out_eob/out_sof
//                     are shared by all channels, out_ch names the channel
//   err_proto         sticky protocol error, cleared only by rst
module dct_arb #(
    parameter int unsigned W    = 8,
    parameter int unsigned N    = 3,
    parameter int unsigned PIPE = 8,
    parameter int unsigned ROWS = 8,
    localparam int unsigned CW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N-1:0]                req_valid,
    input  logic [N-1:0][7:0][W-1:0]    req_data,
    input  logic [N-1:0]                req_sob,
    input  logic [N-1:0]                req_eob,
    input  logic [N-1:0]                req_sof,
    output logic [N-1:0]                req_ready,
    output logic                        dct_valid,
    output logic [7:0][W-1:0]           dct_data,
    output logic                        dct_sob,
    output logic                        dct_eob,
    output logic                        dct_sof,
    input  logic                        dct_res_valid,
    input  logic [7:0][15:0]            dct_res_data,
    input  logic                        dct_res_sob,
    input  logic                        dct_res_eob,
    input  logic                        dct_res_sof,
    output logic [N-1:0]                out_valid,
    output logic [7:0][15:0]            out_data,
    output logic                        out_sob,
    output logic                        out_eob,
    output logic                        out_sof,
    output logic [CW-1:0]               out_ch,
    output logic                        err_proto
);

    localparam int unsigned CNTW = $clog2(ROWS + 1);

    typedef enum logic [0:0] {StIdle, StLock} state_e;

    state_e                     state;
    logic [CW-1:0]              ptr;
    logic [CW-1:0]              owner;
    logic [CNTW-1:0]            cnt;
    logic [CW-1:0]              dct_ch;
    logic [PIPE-1:0]            tag_v;
    logic [PIPE-1:0][CW-1:0]    tag_ch;

    logic [CW-1:0]              cand;
    logic                       cand_found;
    logic [CW-1:0]              sel;
    logic                       acc;
    logic                       drop;
    logic [CNTW-1:0]            row_n;
    logic                       last;
    logic                       row_err;
    logic                       tag_err;
    logic [CW-1:0]              next_ptr;

    function automatic logic [CW-1:0] wrap_idx(input logic [CW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= int'(N)) s = s - int'(N);
        return CW'(s);
    endfunction

    // Search downward so the smallest offset from ptr wins.
    always_comb begin
        cand       = '0;
        cand_found = 1'b0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (req_valid[wrap_idx(ptr, k)]) begin
                cand       = wrap_idx(ptr, k);
                cand_found = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst) begin
            if (state == StLock) begin
                req_ready[owner] = 1'b1;
            end else if (cand_found) begin
                req_ready[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        sel      = (state == StLock) ? owner : cand;
        acc      = !rst && req_valid[sel] && ((state == StLock) || cand_found);
        drop     = acc && (state == StIdle) && !req_sob[sel];
        row_n    = (state == StIdle) ? CNTW'(1) : cnt + CNTW'(1);
        last     = req_eob[sel] || (row_n == CNTW'(ROWS));
        // Premature eob, missing eob on the final row, or a stray sob mid-block.
        row_err  = acc && !drop &&
                   ((req_eob[sel] && (row_n < CNTW'(ROWS))) ||
                    (!req_eob[sel] && (row_n == CNTW'(ROWS))) ||
                    ((state == StLock) && req_sob[sel]));
        tag_err  = dct_res_valid ^ tag_v[PIPE-1];
        next_ptr = (sel == CW'(N - 1)) ? '0 : sel + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            ptr       <= '0;
            owner     <= '0;
            cnt       <= '0;
            dct_valid <= 1'b0;
            dct_data  <= '0;
            dct_sob   <= 1'b0;
            dct_eob   <= 1'b0;
            dct_sof   <= 1'b0;
            dct_ch    <= '0;
            tag_v     <= '0;
            tag_ch    <= '0;
            out_valid <= '0;
            out_data  <= '0;
            out_sob   <= 1'b0;
            out_eob   <= 1'b0;
            out_sof   <= 1'b0;
            out_ch    <= '0;
            err_proto <= 1'b0;
        end else begin
            // Engine-side row register.
            dct_valid <= 1'b0;
            dct_sob   <= 1'b0;
            dct_eob   <= 1'b0;
            dct_sof   <= 1'b0;
            if (acc && !drop) begin
                dct_valid <= 1'b1;
                dct_data  <= req_data[sel];
                dct_sob   <= (state == StIdle);
                dct_eob   <= last;
                dct_sof   <= req_sof[sel];
                dct_ch    <= sel;
                if (last) begin
                    state <= StIdle;
                    ptr   <= next_ptr;
                    cnt   <= '0;
                end else begin
                    state <= StLock;
                    owner <= sel;
                    cnt   <= row_n;
                end
            end

            // Tag stage PIPE-1 lines up with the engine result of the same row.
            tag_v[0]  <= dct_valid;
            tag_ch[0] <= dct_ch;
            for (int i = 1; i < int'(PIPE); i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_ch[i] <= tag_ch[i-1];
            end

            out_valid <= '0;
            out_sob   <= 1'b0;
            out_eob   <= 1'b0;
            out_sof   <= 1'b0;
            if (dct_res_valid && tag_v[PIPE-1]) begin
                out_valid[tag_ch[PIPE-1]] <= 1'b1;
                out_ch                    <= tag_ch[PIPE-1];
                out_data                  <= dct_res_data;
                out_sob                   <= dct_res_sob;
                out_eob                   <= dct_res_eob;
                out_sof                   <= dct_res_sof;
            end

            if (drop || row_err || tag_err) begin
                err_proto <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dct_arb.sv
// Randomized bench for dct_arb with a transaction-level reference model and a
// simple engine model (fixed latency, per-lane affine transform).
module tb_dct_arb;

    localparam int W    = 8;
    localparam int N    = 3;
    localparam int PIPE = 8;
    localparam int ROWS = 8;
    localparam int CW   = 2;
    localparam int NCYC = 3000;
    localparam int MAXC = NCYC + PIPE + 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N-1:0]             req_valid;
    logic [N-1:0][7:0][W-1:0] req_data;
    logic [N-1:0]             req_sob, req_eob, req_sof;
    logic [N-1:0]             req_ready;
    logic                     dct_valid;
    logic [7:0][W-1:0]        dct_data;
    logic                     dct_sob, dct_eob, dct_sof;
    logic                     dct_res_valid;
    logic [7:0][15:0]         dct_res_data;
    logic                     dct_res_sob, dct_res_eob, dct_res_sof;
    logic [N-1:0]             out_valid;
    logic [7:0][15:0]         out_data;
    logic                     out_sob, out_eob, out_sof;
    logic [CW-1:0]            out_ch;
    logic                     err_proto;

    always #5 clk = ~clk;

    dct_arb #(.W(W), .N(N), .PIPE(PIPE), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_sob(req_sob),
        .req_eob(req_eob), .req_sof(req_sof), .req_ready(req_ready),
        .dct_valid(dct_valid), .dct_data(dct_data), .dct_sob(dct_sob),
        .dct_eob(dct_eob), .dct_sof(dct_sof),
        .dct_res_valid(dct_res_valid), .dct_res_data(dct_res_data),
        .dct_res_sob(dct_res_sob), .dct_res_eob(dct_res_eob), .dct_res_sof(dct_res_sof),
        .out_valid(out_valid), .out_data(out_data), .out_sob(out_sob),
        .out_eob(out_eob), .out_sof(out_sof), .out_ch(out_ch), .err_proto(err_proto)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [127:0] xform(input logic [63:0] row);
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'(int'(row[i*8 +: 8]) * 3 - 100);
        return r;
    endfunction

    // Expected result stream, indexed by the cycle it must appear on.
    logic [N-1:0] xo_valid [MAXC];
    logic [127:0] xo_data  [MAXC];
    logic [2:0]   xo_flags [MAXC];
    int           xo_ch    [MAXC];
    // Engine model pipeline, indexed by the cycle its result is presented.
    logic         eng_v    [MAXC];
    logic [127:0] eng_d    [MAXC];
    logic [2:0]   eng_f    [MAXC];

    // Reference model state.
    bit           m_busy, m_err;
    int           m_owner, m_ptr, m_cnt;
    bit           xd_v, xd_sob, xd_eob, xd_sof, post_rst;
    logic [63:0]  xd_data;
    int           g_row [N];
    int           g_blk [N];

    initial begin
        bit in_rst, seg_b, spur, ok, acc, last;
        int prob, ch, n;
        logic [N-1:0] exp_ready;

        for (int i = 0; i < MAXC; i++) begin
            xo_valid[i] = '0; xo_data[i] = '0; xo_flags[i] = '0; xo_ch[i] = 0;
            eng_v[i] = 1'b0; eng_d[i] = '0; eng_f[i] = '0;
        end
        for (int c = 0; c < N; c++) begin g_row[c] = 0; g_blk[c] = 0; end
        m_busy = 0; m_err = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        xd_v = 0; xd_sob = 0; xd_eob = 0; xd_sof = 0; xd_data = '0; post_rst = 0;
        rst = 1'b1; req_valid = '0; req_data = '0; req_sob = '0; req_eob = '0; req_sof = '0;
        dct_res_valid = 1'b0; dct_res_data = '0;
        dct_res_sob = 1'b0; dct_res_eob = 1'b0; dct_res_sof = 1'b0;

        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            in_rst = (cyc < 2) || (cyc == 1000) || (cyc == 2000);
            seg_b  = (cyc > 1000) && (cyc < 2000);
            prob   = (cyc < 300 || cyc > 2000) ? 100 : 70;
            rst    = in_rst;
            for (int c = 0; c < N; c++) begin
                req_valid[c] = ($urandom_range(99) < prob);
                req_sob[c]   = (g_row[c] == 0);
                req_eob[c]   = (g_row[c] == ROWS - 1);
                if (seg_b && $urandom_range(24) == 0) req_sob[c] = ~req_sob[c];
                if (seg_b && $urandom_range(24) == 0) req_eob[c] = ~req_eob[c];
                req_sof[c]   = (g_row[c] == 0) && (g_blk[c] % 4 == 0);
                req_data[c]  = {$urandom, $urandom};
            end

            spur = 0;
            if (!in_rst && cyc >= 2) begin
                dct_res_valid = eng_v[cyc];
                dct_res_data  = eng_d[cyc];
                {dct_res_sob, dct_res_eob, dct_res_sof} = eng_f[cyc];
                if (!eng_v[cyc] && seg_b && $urandom_range(49) == 0) begin
                    spur = 1;
                    dct_res_valid = 1'b1;
                    dct_res_data  = {$urandom, $urandom, $urandom, $urandom};
                end
            end else begin
                dct_res_valid = 1'b0;
                dct_res_data  = '0;
                {dct_res_sob, dct_res_eob, dct_res_sof} = 3'b000;
            end

            // Arbitration decision from the round-robin rules.
            ok = 0; ch = 0;
            if (m_busy) begin
                ok = 1; ch = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (!ok && req_valid[(m_ptr + k) % N]) begin
                        ok = 1; ch = (m_ptr + k) % N;
                    end
                end
            end
            exp_ready = (ok && !in_rst) ? N'(1 << ch) : '0;

            #4;
            if (cyc > 0) begin
                check("req_ready", 128'(req_ready), 128'(exp_ready));
                check("dct_valid", 128'(dct_valid), 128'(xd_v));
                if (xd_v) begin
                    check("dct_data", 128'(dct_data), 128'(xd_data));
                    check("dct_sob", 128'(dct_sob), 128'(xd_sob));
                    check("dct_eob", 128'(dct_eob), 128'(xd_eob));
                    check("dct_sof", 128'(dct_sof), 128'(xd_sof));
                end
                check("out_valid", 128'(out_valid), 128'(xo_valid[cyc]));
                if (xo_valid[cyc] != '0) begin
                    check("out_data", out_data, xo_data[cyc]);
                    check("out_ch", 128'(out_ch), 128'(xo_ch[cyc]));
                    check("out_flags", 128'({out_sob, out_eob, out_sof}), 128'(xo_flags[cyc]));
                end
                check("err_proto", 128'(err_proto), 128'(m_err));
                if (post_rst) begin
                    check("rst_dct_data", 128'(dct_data), 128'(0));
                    check("rst_dct_flags", 128'({dct_sob, dct_eob, dct_sof}), 128'(0));
                    check("rst_out_data", out_data, 128'(0));
                    check("rst_out_ch", 128'({out_ch, out_sob, out_eob, out_sof}), 128'(0));
                end
            end

            // Model update for this cycle's edge.
            xd_v = 0;
            post_rst = 0;
            if (in_rst) begin
                m_busy = 0; m_err = 0; m_ptr = 0; m_cnt = 0; m_owner = 0;
                post_rst = 1;
                for (int i = cyc + 1; i < MAXC && i <= cyc + PIPE + 2; i++) xo_valid[i] = '0;
                for (int i = cyc + 1; i < MAXC && i <= cyc + PIPE; i++) eng_v[i] = 1'b0;
                for (int c = 0; c < N; c++) g_row[c] = 0;
            end else begin
                acc = ok && req_valid[ch];
                if (acc) begin
                    if (!m_busy && !req_sob[ch]) begin
                        m_err = 1;
                    end else begin
                        n = m_busy ? m_cnt + 1 : 1;
                        last = req_eob[ch] || (n == ROWS);
                        if (req_eob[ch] && n < ROWS) m_err = 1;
                        if (!req_eob[ch] && n == ROWS) m_err = 1;
                        if (m_busy && req_sob[ch]) m_err = 1;
                        xd_v = 1; xd_data = req_data[ch];
                        xd_sob = !m_busy; xd_eob = last; xd_sof = req_sof[ch];
                        xo_valid[cyc + PIPE + 2] = N'(1 << ch);
                        xo_data[cyc + PIPE + 2]  = xform(req_data[ch]);
                        xo_flags[cyc + PIPE + 2] = {!m_busy, last, req_sof[ch]};
                        xo_ch[cyc + PIPE + 2]    = ch;
                        if (last) begin
                            m_busy = 0; m_ptr = (ch + 1) % N;
                        end else begin
                            m_busy = 1; m_owner = ch; m_cnt = n;
                        end
                    end
                    if (g_row[ch] == ROWS - 1 || req_eob[ch]) begin
                        g_row[ch] = 0; g_blk[ch]++;
                    end else begin
                        g_row[ch]++;
                    end
                end
                if (spur) m_err = 1;
                // Engine captures the row on the DCT input this cycle.
                if (cyc >= 1 && dct_valid === 1'b1) begin
                    eng_v[cyc + PIPE] = 1'b1;
                    eng_d[cyc + PIPE] = xform(dct_data);
                    eng_f[cyc + PIPE] = {dct_sob, dct_eob, dct_sof};
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
